// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the forward and inverse round datapaths.
// Purely combinational; no latency and no flow control.
// Byte 0 is bits [127:120]; the state is column-major with bytes 0..3 forming column 0.
package aes_pkg;

   typedef logic [127:0] state_t;

   localparam int NR       = 10;
   localparam int RK_IDX_W = 4;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Row r rotates right by r columns: byte (r, c) moves to column (c + r) mod 4.
   function automatic state_t inv_shift_rows(input state_t s);
      state_t o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*((c + r) % 4) + r) -: 8] = s[127 - 8*(4*c + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic state_t inv_mix_columns(input state_t s);
      state_t     o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 8*(4*c)     -: 8];
         a1 = s[127 - 8*(4*c + 1) -: 8];
         a2 = s[127 - 8*(4*c + 2) -: 8];
         a3 = s[127 - 8*(4*c + 3) -: 8];
         o[127 - 8*(4*c)     -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[127 - 8*(4*c + 1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[127 - 8*(4*c + 2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[127 - 8*(4*c + 3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Arithmetic AES inverse S-box: inverse affine transform, then GF(2^8) inverse (00 maps to 00).
// Combinational, zero latency.
// No flow control; output follows input.
module aes_inv_sbox import aes_pkg::*; (
   input  logic [7:0] a,
   output logic [7:0] y
);

   logic [7:0] b, x2, x3, x6, x12, x15, x30, x60, x120, x240;

   // Inverse via b^254 = b^240 * b^12 * b^2, which also sends 00 to 00.
   always_comb begin
      b    = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      x2   = gf_mul(b, b);
      x3   = gf_mul(x2, b);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      y    = gf_mul(gf_mul(x240, x12), x2);
   end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core, one inverse round per clock, round keys read via rk_idx/rk.
// Latency: start accepted at edge E0, done/pt valid in the cycle after E10.
// No queuing: start is ignored while busy and accepted again in the done cycle.
module aes_inv_cipher import aes_pkg::*; (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [127:0]        ct,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        rk,
   output logic                busy,
   output logic                done,
   output logic [127:0]        pt
);

   typedef enum logic {IDLE, ROUND} fsm_t;

   fsm_t                state, state_nxt;
   logic [RK_IDX_W-1:0] r, r_nxt;
   state_t              s, s_nxt, pt_nxt;
   state_t              shifted, subbed, t;
   logic                done_nxt;

   // Shift before substitution: the two commute byte-wise, and this keeps the sboxes on the register side.
   assign shifted = inv_shift_rows(s);

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_inv_sbox u_inv_sbox (
         .a (shifted[127 - 8*i -: 8]),
         .y (subbed[127 - 8*i -: 8])
      );
   end

   assign t      = subbed ^ rk;
   assign busy   = (state == ROUND);
   assign rk_idx = (state == IDLE) ? RK_IDX_W'(NR) : r;

   always_comb begin
      state_nxt = state;
      r_nxt     = r;
      s_nxt     = s;
      pt_nxt    = pt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               s_nxt     = ct ^ rk;
               r_nxt     = RK_IDX_W'(NR - 1);
               state_nxt = ROUND;
            end
         end
         ROUND: begin
            if (r != '0) begin
               s_nxt = inv_mix_columns(t);
               r_nxt = r - 1'b1;
            end else begin
               pt_nxt    = t;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         s     <= '0;
         pt    <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         r     <= r_nxt;
         s     <= s_nxt;
         pt    <= pt_nxt;
         done  <= done_nxt;
      end
   end

endmodule
